// File: rtl/fp_pkg.sv
// Shared types for the FP adder scheduler: IEEE-754 single-precision view,
// exponent/NaN constants, scheduler FSM states and the result classifier
// used when the FPADD_FLAGS_EN build option is enabled.
package fp_pkg;

  // IEEE-754 binary32 field view.
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

  localparam logic [7:0]  EXP_MAX = 8'hFF;
  localparam logic [31:0] FP_NAN  = 32'h7FFFFFFF;

  // RUN issues, DRAIN waits for in-flight work, HALT is fully idle.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } schedState_t;

  // Classify a result word as {nan, inf, zero}.
  function automatic logic [2:0] fpFlags(input fp32_t v);
    logic isNan;
    logic isInf;
    logic isZero;
    isNan  = (v.exp == EXP_MAX) && (v.mant != 23'd0);
    isInf  = (v.exp == EXP_MAX) && (v.mant == 23'd0);
    isZero = (v.exp == 8'd0)    && (v.mant == 23'd0);
    return {isNan, isInf, isZero};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: grants the first requester found when scanning
// upward from the entry after ptr, wrapping from N-1 back to 0.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  // One extra bit so ptr + offset never overflows before the wrap.
  localparam logic [PW:0] NCOUNT = (PW+1)'(N);

  logic [PW:0] cand;
  logic        found;

  // Scan offsets 1..N from the pointer; the first active request wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    cand  = '0;
    for (int off = 1; off <= N; off++) begin
      cand = {1'b0, ptr} + (PW+1)'(off);
      if (cand >= NCOUNT) begin
        cand = cand - NCOUNT;
      end
      if (!found && req[cand[PW-1:0]]) begin
        grant[cand[PW-1:0]] = 1'b1;
        found               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_add_scheduler.sv
// Shares one fixed-latency FP adder datapath among NREQ requesters.
// Each requester owns one result buffer and may have one operation
// outstanding; issues are arbitrated round-robin, one per cycle.
// Optional build macro: FPADD_FLAGS_EN adds rsp_flags ({nan, inf, zero}),
// registered alongside rsp_data.
module fp_add_scheduler #(
  parameter int NREQ = 4,
  parameter int LAT  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0][31:0] req_a,
  input  logic [NREQ-1:0][31:0] req_b,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [NREQ-1:0][31:0] rsp_data,
`ifdef FPADD_FLAGS_EN
  output logic [NREQ-1:0][2:0]  rsp_flags,
`endif
  output logic                  dp_valid,
  output logic [31:0]           dp_a,
  output logic [31:0]           dp_b,
  input  logic [31:0]           dp_result,
  output logic                  busy
);

  import fp_pkg::*;

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  schedState_t stateCur;
  schedState_t stateNxt;

  logic [PW-1:0]          lastWin;
  logic [NREQ-1:0]        eligible;
  logic [NREQ-1:0]        grant;
  logic [PW-1:0]          winIdx;
  logic                   issueOk;
  logic                   issue;

  logic [LAT-1:0]         validPipe;
  logic [LAT-1:0][PW-1:0] tagPipe;
  logic                   tailValid;
  logic [PW-1:0]          tailTag;
  logic                   inFlight;

  logic [NREQ-1:0]        pendingVec;
  logic [NREQ-1:0]        fullVec;

  // Issues are only allowed while running and enabled, so en dropping
  // blocks new work in the very same cycle, before the FSM has moved.
  assign issueOk   = (stateCur == ST_RUN) && en;
  assign eligible  = req_valid & ~fullVec & ~pendingVec & {NREQ{issueOk}};
  assign issue     = |grant;

  assign tailValid = validPipe[LAT-1];
  assign tailTag   = tagPipe[LAT-1];
  assign inFlight  = |validPipe;

  rr_arbiter #(
    .N  (NREQ),
    .PW (PW)
  ) u_arb (
    .req   (eligible),
    .ptr   (lastWin),
    .grant (grant)
  );

  // Convert the one-hot grant into the winner's index.
  always_comb begin
    winIdx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        winIdx = PW'(i);
      end
    end
  end

  // Drive the datapath from the winner; zeros when idle.
  always_comb begin
    req_ready = grant;
    dp_valid  = issue;
    dp_a      = 32'd0;
    dp_b      = 32'd0;
    if (issue) begin
      dp_a = req_a[winIdx];
      dp_b = req_b[winIdx];
    end
  end

  // Next-state logic for the run/drain/halt controller.
  always_comb begin
    stateNxt = stateCur;
    case (stateCur)
      ST_RUN: begin
        if (!en) begin
          stateNxt = inFlight ? ST_DRAIN : ST_HALT;
        end
      end
      ST_DRAIN: begin
        if (en) begin
          stateNxt = ST_RUN;
        end else if (!inFlight) begin
          stateNxt = ST_HALT;
        end
      end
      ST_HALT: begin
        if (en) begin
          stateNxt = ST_RUN;
        end
      end
      default: stateNxt = ST_HALT;
    endcase
  end

  // Controller state register; reset parks in HALT until en is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateCur <= ST_HALT;
    end else begin
      stateCur <= stateNxt;
    end
  end

  // Round-robin pointer remembers the last winner; reset points at the
  // top entry so requester 0 is scanned first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lastWin <= PW'(NREQ - 1);
    end else if (issue) begin
      lastWin <= winIdx;
    end
  end

  // Valid/tag shift register mirroring the datapath latency; the tail
  // lines up with dp_result for the matching issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validPipe <= '0;
      tagPipe   <= '0;
    end else begin
      validPipe[0] <= issue;
      tagPipe[0]   <= winIdx;
      for (int k = 1; k < LAT; k++) begin
        validPipe[k] <= validPipe[k-1];
        tagPipe[k]   <= tagPipe[k-1];
      end
    end
  end

  // Per-requester outstanding flag and result buffer.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    logic        landHere;
    logic        pendingQ;
    logic        fullQ;
    logic [31:0] dataQ;

    assign landHere = tailValid && (tailTag == PW'(gi));

    // Outstanding from issue until the datapath result is captured.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pendingQ <= 1'b0;
      end else if (grant[gi]) begin
        pendingQ <= 1'b1;
      end else if (landHere) begin
        pendingQ <= 1'b0;
      end
    end

    // Capture the result on landing; free the buffer on handshake. Landing
    // and consuming never coincide because a full buffer blocks re-issue.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        fullQ <= 1'b0;
        dataQ <= 32'd0;
      end else if (landHere) begin
        fullQ <= 1'b1;
        dataQ <= dp_result;
      end else if (fullQ && rsp_ready[gi]) begin
        fullQ <= 1'b0;
      end
    end

`ifdef FPADD_FLAGS_EN
    logic [2:0] flagsQ;

    // Result classification, captured together with the data word.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        flagsQ <= 3'd0;
      end else if (landHere) begin
        flagsQ <= fpFlags(fp32_t'(dp_result));
      end
    end

    assign rsp_flags[gi] = flagsQ;
`endif

    assign pendingVec[gi] = pendingQ;
    assign fullVec[gi]    = fullQ;
    assign rsp_valid[gi]  = fullQ;
    assign rsp_data[gi]   = dataQ;
  end

  assign busy = inFlight | (|fullVec);

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Randomized and directed bench for fp_add_scheduler (NREQ=4, LAT=2).
// The bench plays the FP datapath and keeps a transaction-level model:
// per-requester outstanding flag, due cycle and expected result.
`timescale 1ns/1ps
module tb_fp_add_scheduler;

  localparam int NREQ = 4;
  localparam int LAT  = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  en;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0][31:0] req_a;
  logic [NREQ-1:0][31:0] req_b;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [NREQ-1:0][31:0] rsp_data;
`ifdef FPADD_FLAGS_EN
  logic [NREQ-1:0][2:0]  rsp_flags;
`endif
  logic                  dp_valid;
  logic [31:0]           dp_a;
  logic [31:0]           dp_b;
  logic [31:0]           dp_result;
  logic                  busy;

  always #5 clk = ~clk;

  fp_add_scheduler #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
`ifdef FPADD_FLAGS_EN
    .rsp_flags (rsp_flags),
`endif
    .dp_valid  (dp_valid),
    .dp_a      (dp_a),
    .dp_b      (dp_b),
    .dp_result (dp_result),
    .busy      (busy)
  );

  typedef struct {
    int          due;
    int          tag;
    logic [31:0] val;
  } dpItem_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model state.
  bit              runFlag;
  bit [NREQ-1:0]   outst;
  int              readyAt [NREQ];
  logic [31:0]     expData [NREQ];
  int              lastWin;
  dpItem_t         dpQ [$];

  // Stimulus applied by step().
  logic                  rstIn;
  logic                  enIn;
  logic [NREQ-1:0]       vIn;
  logic [NREQ-1:0][31:0] aIn;
  logic [NREQ-1:0][31:0] bIn;
  logic [NREQ-1:0]       rdyIn;

  // Observations collected by step().
  int lastIssue;
  int issueCount;
  int hsCount;
  int issueCnt [NREQ];

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int          e;
    d = $realtobits(r);
    e = int'(d[62:52]) - 896;
    if (d[62:52] == 11'd0 || e <= 0) return {d[63], 31'd0};
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Behavioural datapath: single-precision add (truncating), NaN/inf aware.
  function automatic logic [31:0] dpFunc(input logic [31:0] a, input logic [31:0] b);
    bit nanA, nanB, infA, infB;
    nanA = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nanB = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    infA = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    infB = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    if (nanA || nanB) return 32'h7FC00000;
    if (infA && infB) return (a[31] != b[31]) ? 32'h7FC00000 : a;
    if (infA) return a;
    if (infB) return b;
    return r2f(f2r(a) + f2r(b));
  endfunction

  function automatic logic [2:0] classify(input logic [31:0] v);
    return {(v[30:23] == 8'hFF) && (v[22:0] != 0),
            (v[30:23] == 8'hFF) && (v[22:0] == 0),
            (v[30:0] == 31'd0)};
  endfunction

  task automatic modelReset();
    runFlag = 0;
    outst   = '0;
    lastWin = NREQ - 1;
    dpQ.delete();
  endtask

  // One clock cycle: drive at negedge, check, then update model at posedge.
  task automatic step();
    logic [NREQ-1:0] expReady;
    logic [NREQ-1:0] expRv;
    logic [31:0]     expA;
    logic [31:0]     expB;
    int              w;
    bit              anyHs;
    bit              collide;
    @(negedge clk);
    rst_n     = rstIn;
    en        = enIn;
    req_valid = vIn;
    req_a     = aIn;
    req_b     = bIn;
    rsp_ready = rdyIn;
    if (dpQ.size() > 0 && dpQ[0].due == cyc) dp_result = dpQ[0].val;
    else dp_result = $urandom;
    #1;
    if (!rst_n) modelReset();
    w = -1;
    if (rst_n && runFlag && en) begin
      for (int k = 1; k <= NREQ; k++) begin
        automatic int i = (lastWin + k) % NREQ;
        if (w < 0 && req_valid[i] && !outst[i]) w = i;
      end
    end
    expReady = '0;
    expA     = 32'd0;
    expB     = 32'd0;
    if (w >= 0) begin
      expReady[w] = 1'b1;
      expA        = req_a[w];
      expB        = req_b[w];
    end
    for (int i = 0; i < NREQ; i++) expRv[i] = outst[i] && (cyc >= readyAt[i]);
    checkVal("req_ready", 32'(req_ready), 32'(expReady));
    checkVal("dp_valid", 32'(dp_valid), (w >= 0) ? 32'd1 : 32'd0);
    checkVal("dp_a", dp_a, expA);
    checkVal("dp_b", dp_b, expB);
    checkVal("rsp_valid", 32'(rsp_valid), 32'(expRv));
    checkVal("busy", 32'(busy), (outst != 0) ? 32'd1 : 32'd0);
    anyHs   = 0;
    collide = 0;
    for (int i = 0; i < NREQ; i++) begin
      if (expRv[i]) begin
        checkVal($sformatf("rsp_data%0d", i), rsp_data[i], expData[i]);
`ifdef FPADD_FLAGS_EN
        checkVal($sformatf("rsp_flags%0d", i), 32'(rsp_flags[i]), 32'(classify(expData[i])));
`endif
        if (rsp_ready[i]) begin
          anyHs = 1;
          foreach (dpQ[j]) if (dpQ[j].due == cyc && dpQ[j].tag == i) collide = 1;
        end
      end
    end
    if (anyHs) checkVal("no_land_on_consume", 32'(collide), 32'd0);
    if (dpQ.size() > 0 && dpQ[0].due == cyc) void'(dpQ.pop_front());
    @(posedge clk);
    lastIssue = w;
    if (rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        if (expRv[i] && rsp_ready[i]) begin
          outst[i] = 0;
          hsCount++;
        end
      end
      if (w >= 0) begin
        outst[w]    = 1;
        readyAt[w]  = cyc + LAT + 1;
        expData[w]  = dpFunc(expA, expB);
        lastWin     = w;
        issueCount++;
        issueCnt[w]++;
        dpQ.push_back('{cyc + LAT, w, expData[w]});
        $display("cycle %0d issue req%0d a=%h b=%h exp=%h", cyc, w, expA, expB, expData[w]);
      end
      runFlag = en;
    end
    cyc++;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic randOps();
    for (int i = 0; i < NREQ; i++) begin
      aIn[i] = ($urandom_range(0, 15) == 0) ? {$urandom_range(0, 1) == 1, 8'hFF, 23'($urandom_range(0, 1))}
                                            : $urandom;
      bIn[i] = $urandom;
    end
  endtask

  initial begin
    int c1;
    int cOthers;
    logic [31:0] held;
    rst_n = 1'b0; en = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    rsp_ready = '0; dp_result = '0;
    rstIn = 1'b0; enIn = 1'b0; vIn = '0; aIn = '0; bIn = '0; rdyIn = '1;
    lastIssue = -1; issueCount = 0; hsCount = 0;
    foreach (issueCnt[i]) issueCnt[i] = 0;
    foreach (readyAt[i]) readyAt[i] = 0;
    foreach (expData[i]) expData[i] = '0;
    modelReset();

    // Reset state, then enter RUN.
    enIn = 1'b1;
    steps(3);
    rstIn = 1'b1;
    vIn   = '0;
    step();

    // All four valid together: 0,1,2,3 then the next round starts at 0.
    randOps();
    vIn = '1;
    for (int k = 0; k < NREQ; k++) begin
      step();
      checkVal("rr_order", 32'(lastIssue), 32'(k));
    end
    step();
    checkVal("rr_next_round", 32'(lastIssue), 32'd0);
    vIn = '0;
    steps(6);

    // Single request, 1.0 + 2.0, held unconsumed to observe the result.
    aIn[0] = 32'h3F800000; bIn[0] = 32'h40000000;
    vIn = 4'b0001; rdyIn = 4'b1110;
    step();
    checkVal("single_issue", 32'(lastIssue), 32'd0);
    vIn = '0;
    steps(2);
    #1;
    checkVal("single_valid", 32'(rsp_valid[0]), 32'd1);
    checkVal("single_data", rsp_data[0], 32'h40400000);
    rdyIn = '1;
    steps(4);

    // Backpressure on requester 1 for ten cycles.
    randOps();
    vIn = '1; rdyIn = 4'b1101;
    foreach (issueCnt[i]) issueCnt[i] = 0;
    steps(4);
    held = rsp_data[1];
    steps(6);
    c1 = issueCnt[1];
    cOthers = issueCnt[0] + issueCnt[2] + issueCnt[3];
    checkVal("bp_req1_single_issue", (c1 <= 1) ? 32'd1 : 32'd0, 32'd1);
    checkVal("bp_data_stable", rsp_data[1], held);
    checkVal("bp_others_progress", (cOthers >= 5) ? 32'd1 : 32'd0, 32'd1);
    rdyIn = '1; vIn = '0;
    steps(6);

    // en falls with two operations in flight: drain, then halt.
    randOps();
    vIn = 4'b0011;
    steps(2);
    vIn = '1; enIn = 1'b0;
    issueCount = 0; hsCount = 0;
    steps(8);
    checkVal("drain_no_issue", 32'(issueCount), 32'd0);
    checkVal("drain_delivered", 32'(hsCount), 32'd2);
    checkVal("halt_idle", 32'(busy), 32'd0);
    enIn = 1'b1; vIn = '0;
    step();

    // Asynchronous reset with work in flight.
    randOps();
    vIn = '1;
    steps(4);
    #2;
    rst_n = 1'b0; rstIn = 1'b0;
    #1;
    checkVal("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkVal("arst_busy", 32'(busy), 32'd0);
    checkVal("arst_dp_valid", 32'(dp_valid), 32'd0);
    modelReset();
    vIn = '0;
    steps(2);
    rstIn = 1'b1;
    hsCount = 0;
    steps(8);
    checkVal("no_stale_result", 32'(hsCount), 32'd0);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      enIn  = ($urandom_range(0, 15) != 0);
      vIn   = NREQ'($urandom);
      rdyIn = NREQ'($urandom) | NREQ'($urandom);
      randOps();
      step();
    end
    enIn = 1'b1; vIn = '0; rdyIn = '1;
    steps(6);

`ifdef FPADD_FLAGS_EN
    // Flag classification of NaN, infinity and zero results.
    aIn[0] = 32'h7FC00000; bIn[0] = 32'h00000000;
    vIn = 4'b0001; rdyIn = 4'b1110;
    step(); vIn = '0; steps(2); #1;
    checkVal("flags_nan", 32'(rsp_flags[0]), 32'd4);
    rdyIn = '1; steps(2);
    aIn[0] = 32'h7F800000; bIn[0] = 32'h3F800000;
    vIn = 4'b0001; rdyIn = 4'b1110;
    step(); vIn = '0; steps(2); #1;
    checkVal("flags_inf", 32'(rsp_flags[0]), 32'd2);
    rdyIn = '1; steps(2);
    aIn[0] = 32'h00000000; bIn[0] = 32'h00000000;
    vIn = 4'b0001; rdyIn = 4'b1110;
    step(); vIn = '0; steps(2); #1;
    checkVal("flags_zero", 32'(rsp_flags[0]), 32'd1);
    rdyIn = '1; steps(2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
